// File: rtl/sdram_avalon_arb_pkg.sv
// Shared constants for the two-master SDRAM Avalon arbiter: one-hot grant
// states, master IDs and the request-decode helper.
package sdram_arb_pkg;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_GNT0 = 3'b010;
  localparam logic [2:0] ST_GNT1 = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_GNT0 = ST_GNT0,
    S_GNT1 = ST_GNT1
  } state_e;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  // A master is requesting when selected with either strobe low.
  function automatic logic is_req(input logic cs, input logic rd_n, input logic wr_n);
    return cs & (~rd_n | ~wr_n);
  endfunction

endpackage

// File: rtl/sdram_avalon_arb_if.sv
// Avalon-MM bus bundle (active-low strobes and byte enables, pipelined reads).
interface sdram_avalon_arb_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable_n;
  logic              chipselect;
  logic [DATA_W-1:0] writedata;
  logic              read_n;
  logic              write_n;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable_n, chipselect, writedata, read_n, write_n,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable_n, chipselect, writedata, read_n, write_n,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_avalon_arb_id_fifo.sv
// Pending-read queue: a DEPTH-entry FIFO of 1-bit master IDs (DEPTH a power of 2).
module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic head_o,
  output logic empty_o,
  output logic full_o
);
  localparam int PW = $clog2(DEPTH);

  logic          mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      // Push and pop together leave the count unchanged.
      if (do_push && !do_pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_id_i;
  end
endmodule

// File: rtl/sdram_avalon_arb.sv
// Two-master arbiter for one Avalon-MM SDRAM slave; zero-latency command path,
// in-order read return. Define SDRAM_ARB_RR_EN for round-robin, else m0 has priority.
module sdram_avalon_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int MAX_PEND = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_avalon_arb_if.slave    m0,
  sdram_avalon_arb_if.slave    m1,
  sdram_avalon_arb_if.master   s,
  output logic                 err_unexp_rdv
);
  state_e state_q, state_d;
  logic   req0, req1, rd0, rd1, gnt0, gnt1;
  logic   g_req, g_rd, other_req, blk, acc, push, pop;
  logic   pend_head, pend_empty, pend_full;
  logic   pick_m1, switch_ok, err_q;

  assign req0 = is_req(m0.chipselect, m0.read_n, m0.write_n);
  assign req1 = is_req(m1.chipselect, m1.read_n, m1.write_n);
  // Read+write together is a write, so only a pure read uses the queue.
  assign rd0  = m0.chipselect & ~m0.read_n & m0.write_n;
  assign rd1  = m1.chipselect & ~m1.read_n & m1.write_n;
  assign gnt0 = (state_q == S_GNT0);
  assign gnt1 = (state_q == S_GNT1);

  assign g_req     = (gnt0 & req0) | (gnt1 & req1);
  assign g_rd      = (gnt0 & rd0) | (gnt1 & rd1);
  assign other_req = gnt0 ? req1 : req0;
  assign blk       = g_rd & pend_full;
  assign acc       = g_req & ~s.waitrequest & ~blk;
  assign push      = acc & g_rd;
  assign pop       = s.readdatavalid & ~pend_empty;

`ifdef SDRAM_ARB_RR_EN
  logic last_q, last_d;

  assign pick_m1   = req1 & (~req0 | (last_q == ID_M0));
  assign switch_ok = 1'b1;
  assign last_d    = acc ? (gnt1 ? ID_M1 : ID_M0) : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= ID_M1;
    else        last_q <= last_d;
  end
`else
  assign pick_m1   = req1 & ~req0;
  // Only an m1 grant yields early, and only to a requesting m0.
  assign switch_ok = gnt1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (s.readdatavalid && pend_empty) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    s.address        = {ADDR_W{1'b0}};
    s.byteenable_n   = {BE_W{1'b1}};
    s.chipselect     = 1'b0;
    s.writedata      = {DATA_W{1'b0}};
    s.read_n         = 1'b1;
    s.write_n        = 1'b1;
    m0.waitrequest   = 1'b1;
    m1.waitrequest   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) state_d = pick_m1 ? S_GNT1 : S_GNT0;
      end
      S_GNT0, S_GNT1: begin
        if (acc) begin
          if (other_req && switch_ok) state_d = gnt0 ? S_GNT1 : S_GNT0;
          else if (!g_req)            state_d = S_IDLE;
        end else if (!g_req) begin
          state_d = S_IDLE;
        end
        if (gnt0) begin
          s.address      = m0.address;
          s.byteenable_n = m0.byteenable_n;
          s.chipselect   = m0.chipselect;
          s.writedata    = m0.writedata;
          s.read_n       = m0.read_n | blk;
          s.write_n      = m0.write_n;
          m0.waitrequest = s.waitrequest | blk;
        end else begin
          s.address      = m1.address;
          s.byteenable_n = m1.byteenable_n;
          s.chipselect   = m1.chipselect;
          s.writedata    = m1.writedata;
          s.read_n       = m1.read_n | blk;
          s.write_n      = m1.write_n;
          m1.waitrequest = s.waitrequest | blk;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  arb_id_fifo #(.DEPTH(MAX_PEND)) u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_id_i (gnt1 ? ID_M1 : ID_M0),
    .pop_i     (pop),
    .head_o    (pend_head),
    .empty_o   (pend_empty),
    .full_o    (pend_full)
  );

  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = pop & (pend_head == ID_M0);
  assign m1.readdatavalid = pop & (pend_head == ID_M1);
  assign err_unexp_rdv    = err_q;
endmodule

// File: doc/sdram_avalon_arb.md
Name: sdram_avalon_arb

Overview:
- Two-master arbiter for the single Avalon-MM SDRAM slave port (16-bit data, active-low read_n/write_n/byteenable_n, waitrequest, pipelined readdatavalid).
- Lets two independent requesters share one SDRAM controller, for example a UART ingest writer and a readback/scrub engine.
- Command path is combinational from the granted master (zero added latency).
- Read responses are routed back in order through an outstanding-read ID queue.

Parameters:
- ADDR_W, 24, address width.
- DATA_W, 16, data width.
- BE_W, 2, byteenable width.
- MAX_PEND, 4, maximum outstanding reads across both masters (power of 2, ≥2).

Ports:
Each mN_* line is instantiated twice, for N=0 and N=1.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mN_address  in  ADDR_W  master word address
- mN_byteenable_n  in  BE_W  master byte enables, active-low
- mN_chipselect  in  1  master chipselect
- mN_writedata  in  DATA_W  master write data
- mN_read_n  in  1  master read strobe, active-low
- mN_write_n  in  1  master write strobe, active-low
- mN_waitrequest  out  1  stall to master
- mN_readdata  out  DATA_W  read data, broadcast to both masters
- mN_readdatavalid  out  1  read data valid, routed to the owning master
- s_address  out  ADDR_W  to SDRAM controller
- s_byteenable_n  out  BE_W  to SDRAM controller
- s_chipselect  out  1  to SDRAM controller
- s_writedata  out  DATA_W  to SDRAM controller
- s_read_n  out  1  to SDRAM controller
- s_write_n  out  1  to SDRAM controller
- s_readdata  in  DATA_W  from SDRAM controller
- s_readdatavalid  in  1  from SDRAM controller
- s_waitrequest  in  1  from SDRAM controller
- err_unexp_rdv  out  1  sticky flag: readdatavalid arrived with no pending read

Behaviour:
- Clock and reset: clk, rst_n; reset is asynchronous, active-low.
- Request decode: reqN = mN_chipselect & (~mN_read_n | ~mN_write_n). Read and write asserted together counts as a write.
- States (one-hot): IDLE, GNT0, GNT1. Reset state is IDLE.
- IDLE: if any reqN, the arbitration policy picks a master and the state moves to GNTN next cycle. The command is not forwarded while in IDLE.
- Transfer accepted in GNTN when: reqN & ~s_waitrequest & ~blk. blk = (read request) & pend_full.
- GNTN, accepted transfer:
  - if the other master is requesting and policy allows a switch, move to GNT(other);
  - else stay if reqN;
  - else go to IDLE.
- GNTN, reqN deasserts without a transfer: go to IDLE.
- GNTN, granted master still requesting but not accepted: hold the grant. No preemption mid-transfer.
- Slave outputs in GNTN: all s_* command fields equal master N's fields, except s_read_n is forced to 1 while blk.
- Slave outputs in IDLE: s_chipselect=0, s_read_n=1, s_write_n=1, s_byteenable_n=all 1, s_address=0, s_writedata=0. These are also the reset values.
- mN_waitrequest:
  - granted master: s_waitrequest | blk;
  - non-granted master: 1 whenever reqN;
  - otherwise 1;
  - reset value 1.
- Pending queue: MAX_PEND × 1-bit FIFO of master IDs.
  - Push the granted ID on each accepted read.
  - Pop on s_readdatavalid.
  - Simultaneous push and pop in the same cycle is legal; the count stays unchanged.
  - pend_full is computed from the registered count. A pop in the same cycle does not unblock until the next cycle.
- Read return routing:
  - mN_readdatavalid = s_readdatavalid & ~pend_empty & (head==N);
  - readdata is combinational pass-through.
- s_readdatavalid while the queue is empty: dropped (no mN_readdatavalid) and err_unexp_rdv set to 1. It clears only on reset.
- Reset mid-operation: grant returns to IDLE and the queue is flushed. Late readdatavalid after reset is dropped and flags the error.
- Writes do not use the queue; write-only traffic is never blocked by pend_full.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined: round-robin.
  - A last-granted register (reset value 1, so m0 wins the first tie).
  - On a tie, the master that was not last granted wins.
  - After each accepted transfer, the grant switches if the other master is requesting.
- Undefined: fixed priority, m0 > m1.
  - m1 is granted only when m0 is not requesting.
  - After an accepted m1 transfer, the grant switches to m0 if m0 is requesting.

Decomposition:
- Package sdram_arb_pkg: state one-hot localparams (ST_IDLE, ST_GNT0, ST_GNT1), master ID constants (ID_M0=0, ID_M1=1).
- Sub-module arb_id_fifo: parameterised depth, 1-bit wide, with push, pop, head, empty, full. This holds the pending-read queue.

Test Plan:
- Write-only: m0 writes addr 0x000005, data 0xA55A, s_waitrequest=0. Expect s_write_n=0, s_address=0x000005, s_writedata=0xA55A one cycle after the request (IDLE→GNT0). m1_waitrequest stays 1 throughout.
- Contention: both masters stream 4 writes each, s_waitrequest=0.
  - RR_EN: accept order m0, m1, m0, m1, m0, m1, m0, m1.
  - Without RR_EN: all four m0 writes, then four m1 writes.
- Read routing: m0 reads 0x10 and 0x11, then m1 reads 0x20. Slave returns 0x1111, 0x2222, 0x3333 with 3-cycle latency. Expect m0_readdatavalid on the first two returns, m1_readdatavalid on the third; err_unexp_rdv stays 0.
- Backpressure: 4 reads outstanding (MAX_PEND=4), 5th read requested. Expect s_read_n=1 and mN_waitrequest=1 until the first s_readdatavalid, then the 5th read is accepted the next cycle.
- Slave stall: s_waitrequest=1 for 5 cycles during an m1 write while m0 requests. Expect the grant held on m1 and m1 fields stable on s_*; m0 is granted only after the m1 write is accepted.
- Error and reset: s_readdatavalid pulsed with the queue empty → err_unexp_rdv=1, no mN_readdatavalid. Reset asserted mid-read → all outputs at reset values, flag cleared, queue empty.
